// File: rtl/accumulator_drain.sv
// accumulator_drain: snapshots one accumulator column and streams it oldest-first over valid/ready.
// Define ACC_DRAIN_OVERRUN_EN to add a sticky overrun_o flag for loads dropped during a drain.
module accumulator_drain #(
  parameter int N = 4,
  parameter int NUM_BITS = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NUM_BITS-1:0] product_i [N],
  input  logic                load_i,
  output logic                load_ready_o,
  output logic [NUM_BITS-1:0] data_o,
  output logic                data_valid_o,
  input  logic                data_ready_i,
  output logic                data_last_o,
  output logic                busy_o
`ifdef ACC_DRAIN_OVERRUN_EN
  ,
  output logic                overrun_o
`endif
);
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic [NUM_BITS-1:0] snap [N];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx <= '0;
      for (int i = 0; i < N; i++) snap[i] <= '0;
    end else if (state == IDLE) begin
      if (load_i) begin
        snap <= product_i;
        idx <= IW'(N - 1);
        state <= DRAIN;
      end
    end else if (data_ready_i) begin
      if (idx == '0) state <= IDLE;
      else idx <= idx - 1'b1;
    end
  end
  // Outputs decode only registered state, so valid never depends on ready.
  always_comb begin
    busy_o = state == DRAIN;
    data_valid_o = busy_o;
    load_ready_o = state == IDLE && !rst_i;
    data_o = busy_o ? snap[idx] : '0;
    data_last_o = busy_o && idx == '0;
  end
`ifdef ACC_DRAIN_OVERRUN_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) overrun_o <= 1'b0;
    else if (state == DRAIN && load_i) overrun_o <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_accumulator_drain.sv
// tb_accumulator_drain: directed scoreboard bench for accumulator_drain (N=4 and N=1 instances).
module tb_accumulator_drain;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] prod [4];
  logic load = 1'b0, rdy = 1'b0;
  logic lr, dv, last, busy;
  logic [31:0] data;
  logic [31:0] p1 [1];
  logic ld1 = 1'b0, rdy1 = 1'b0;
  logic lr1, dv1, last1, busy1;
  logic [31:0] d1;
`ifdef ACC_DRAIN_OVERRUN_EN
  logic ovr, ovr1;
`endif
  int total = 0, bad = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  accumulator_drain #(.N(4), .NUM_BITS(32)) dut (
    .clk_i(clk), .rst_i(rst), .product_i(prod), .load_i(load), .load_ready_o(lr),
    .data_o(data), .data_valid_o(dv), .data_ready_i(rdy), .data_last_o(last), .busy_o(busy)
`ifdef ACC_DRAIN_OVERRUN_EN
    , .overrun_o(ovr)
`endif
  );

  accumulator_drain #(.N(1), .NUM_BITS(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .product_i(p1), .load_i(ld1), .load_ready_o(lr1),
    .data_o(d1), .data_valid_o(dv1), .data_ready_i(rdy1), .data_last_o(last1), .busy_o(busy1)
`ifdef ACC_DRAIN_OVERRUN_EN
    , .overrun_o(ovr1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [31:0] base);
    for (int i = 0; i < 4; i++) prod[i] = base * (i + 1);
    chk("load_ready_before_load", lr, 1);
    load = 1'b1;
    cyc();
    load = 1'b0;
    for (int i = 3; i >= 0; i--) q.push_back(base * (i + 1));
  endtask

  // Pattern bit c gives ready in drain cycle c; beyond plen ready stays high.
  task automatic drain(input logic [15:0] pat, input int plen, input bit junk, input int maxb);
    int beats = 0;
    int c = 0;
    bit b;
    while (q.size() > 0 && beats < maxb && c < 40) begin
      rdy = (c < plen) ? pat[c] : 1'b1;
      if (junk) begin
        load = 1'b1;
        for (int i = 0; i < 4; i++) prod[i] = 32'hAA;
      end
      chk("valid", dv, 1);
      chk("busy", busy, 1);
      chk("load_ready_in_drain", lr, 0);
      chk("data", data, q[0]);
      chk("last", last, q.size() == 1);
      b = dv && rdy;
      cyc();
      if (b) begin
        void'(q.pop_front());
        beats++;
      end
      c++;
    end
    load = 1'b0;
    rdy = 1'b0;
    if (c >= 40) chk("drain_timeout", 32'(c), 0);
  endtask

  task automatic check_idle();
    chk("idle_load_ready", lr, 1);
    chk("idle_valid", dv, 0);
    chk("idle_busy", busy, 0);
    chk("idle_last", last, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) prod[i] = '0;
    p1[0] = '0;
    #3;
    chk("rst_valid", dv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data, 0);
    chk("rst_last", last, 0);
    chk("rst_load_ready", lr, 0);
    cyc();
    rst = 1'b0;
    #1;
    check_idle();
    // Straight drain with ready high: four consecutive beats.
    do_load(32'h11);
    drain(16'h0, 0, 1'b0, 4);
    chk("sb_empty_1", 32'(q.size()), 0);
    check_idle();
    // Ready toggling 1,0,0,1,1,0,1.
    do_load(32'h11);
    drain(16'b1011001, 7, 1'b0, 4);
    chk("sb_empty_2", 32'(q.size()), 0);
    check_idle();
    // Product changes after the snapshot must not leak.
    do_load(32'h11);
    for (int i = 0; i < 4; i++) prod[i] = 32'hFF;
    drain(16'b0101, 4, 1'b0, 4);
    chk("sb_empty_3", 32'(q.size()), 0);
    check_idle();
`ifdef ACC_DRAIN_OVERRUN_EN
    chk("overrun_clear", ovr, 0);
`endif
    // Loads with new data every drain cycle, including the final beat, are dropped.
    do_load(32'h11);
    drain(16'h0, 0, 1'b1, 4);
    chk("sb_empty_4", 32'(q.size()), 0);
    check_idle();
`ifdef ACC_DRAIN_OVERRUN_EN
    chk("overrun_set", ovr, 1);
    cyc();
    chk("overrun_sticky", ovr, 1);
`endif
    // Asynchronous reset after two beats.
    do_load(32'h21);
    drain(16'h0, 0, 1'b0, 2);
    chk("sb_two_left", 32'(q.size()), 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", dv, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", data, 0);
    chk("arst_last", last, 0);
    q.delete();
    #2 rst = 1'b0;
    #1;
    check_idle();
`ifdef ACC_DRAIN_OVERRUN_EN
    chk("overrun_after_rst", ovr, 0);
`endif
    cyc();
    do_load(32'h101);
    drain(16'b0110, 4, 1'b0, 4);
    chk("sb_empty_5", 32'(q.size()), 0);
    check_idle();
    // Single-word column.
    p1[0] = 32'hDEADBEEF;
    chk("n1_load_ready", lr1, 1);
    ld1 = 1'b1;
    rdy1 = 1'b1;
    cyc();
    ld1 = 1'b0;
    chk("n1_valid", dv1, 1);
    chk("n1_data", d1, 32'hDEADBEEF);
    chk("n1_last", last1, 1);
    chk("n1_busy", busy1, 1);
    cyc();
    chk("n1_idle_valid", dv1, 0);
    chk("n1_idle_load_ready", lr1, 1);
    chk("n1_idle_data", d1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
